// File: rtl/eq_band_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eq_band_scheduler
// Description : Time-shares one FIR band engine across NUM_BANDS equalizer
//               bands, applies per-band gains and sums into one output sample.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_band_scheduler #(
    parameter int NUM_BANDS   = 5,
    parameter int GAIN_FRAC   = 14,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_data,
    input  logic [15:0] x_in,
    output logic        eng_start,
    output logic [2:0]  eng_band,
    output logic [15:0] eng_x,
    input  logic        eng_done,
    input  logic [15:0] eng_y,
    input  logic        gain_we,
    input  logic [2:0]  gain_addr,
    input  logic [15:0] gain_wdata,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic        busy,
    output logic        overrun,
    output logic        eng_timeout
);

    localparam int            CW          = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_TIMEOUT   = CW'(TIMEOUT_CYC);
    localparam logic [2:0]    C_LAST_BAND = 3'(NUM_BANDS - 1);
    localparam logic [15:0]   C_UNITY     = 16'(1 << GAIN_FRAC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SCALE = 3'd3,
        S_ACC   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_gain_stg [NUM_BANDS];
    logic [15:0]          r_gain_act [NUM_BANDS];
    logic [CW-1:0]        r_wait_cnt;
    logic signed [15:0]   r_band_y;
    logic signed [32:0]   r_prod;
    logic signed [35:0]   r_acc;
    logic signed [32:0]   w_prod;
    logic signed [35:0]   w_shift;
    logic [15:0]          w_sat;
    logic                 w_accept;
    logic                 w_wait_tmo;

    // The y_valid cycle is still part of the sample, so it blocks acceptance.
    assign busy       = (r_state != S_IDLE) || y_valid;
    assign w_accept   = new_data && (r_state == S_IDLE) && !y_valid;
    assign w_wait_tmo = (r_wait_cnt == C_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (eng_done || w_wait_tmo) w_state_nxt = S_SCALE;
            S_SCALE: w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = (eng_band == C_LAST_BAND) ? S_OUT : S_ISSUE;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_prod  = 33'(r_band_y) * 33'($signed({1'b0, r_gain_act[eng_band]}));
    assign w_shift = r_acc >>> GAIN_FRAC;

    always_comb begin
        w_sat = w_shift[15:0];
        if (w_shift > 36'sd32767) begin
            w_sat = 16'h7FFF;
        end else if (w_shift < -36'sd32768) begin
            w_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_gain_stg[i] <= C_UNITY;
                r_gain_act[i] <= C_UNITY;
            end
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (gain_we && (gain_addr == 3'(i))) begin
                    r_gain_stg[i] <= gain_wdata;
                end
                if (w_accept) begin
                    r_gain_act[i] <= (gain_we && (gain_addr == 3'(i))) ? gain_wdata : r_gain_stg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_start   <= 1'b0;
            eng_band    <= 3'd0;
            eng_x       <= 16'd0;
            y_out       <= 16'd0;
            y_valid     <= 1'b0;
            overrun     <= 1'b0;
            eng_timeout <= 1'b0;
            r_wait_cnt  <= '0;
            r_band_y    <= 16'sd0;
            r_prod      <= 33'sd0;
            r_acc       <= 36'sd0;
        end else begin
            eng_start <= (r_state == S_ISSUE);
            y_valid   <= (r_state == S_OUT);
            if (new_data && !w_accept) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        eng_x    <= x_in;
                        eng_band <= 3'd0;
                        r_acc    <= 36'sd0;
                    end
                end
                S_ISSUE: r_wait_cnt <= '0;
                S_WAIT: begin
                    if (eng_done) begin
                        r_band_y <= eng_y;
                    end else if (w_wait_tmo) begin
                        r_band_y    <= 16'sd0;
                        eng_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_SCALE: r_prod <= w_prod;
                S_ACC: begin
                    r_acc <= r_acc + {{3{r_prod[32]}}, r_prod};
                    if (eng_band != C_LAST_BAND) begin
                        eng_band <= eng_band + 3'd1;
                    end
                end
                S_OUT:   y_out <= w_sat;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_band_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eq_band_scheduler
// Description : Directed self-checking bench for eq_band_scheduler with a
//               behavioural single-cycle FIR engine responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_band_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_data = 1'b0;
    logic [15:0] x_in = 16'd0;
    logic        eng_start;
    logic [2:0]  eng_band;
    logic [15:0] eng_x;
    logic        eng_done = 1'b0;
    logic [15:0] eng_y = 16'd0;
    logic        gain_we = 1'b0;
    logic [2:0]  gain_addr = 3'd0;
    logic [15:0] gain_wdata = 16'd0;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;
    logic        eng_timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    int          eng_mode = 0;
    logic [15:0] eng_const = 16'd0;
    int          withhold_band = -1;
    int          start_cnt = 0;
    int          yv_cnt = 0;
    int          xbad_cnt = 0;
    logic [15:0] exp_x = 16'd0;
    int          band_log[$];

    eq_band_scheduler #(
        .NUM_BANDS  (5),
        .GAIN_FRAC  (14),
        .TIMEOUT_CYC(15)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_data   (new_data),
        .x_in       (x_in),
        .eng_start  (eng_start),
        .eng_band   (eng_band),
        .eng_x      (eng_x),
        .eng_done   (eng_done),
        .eng_y      (eng_y),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun),
        .eng_timeout(eng_timeout)
    );

    always #5 clk = ~clk;

    // Engine model: answers one cycle after it sees eng_start.
    initial begin
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (eng_start && rst_n && (int'(eng_band) != withhold_band)) begin
                @(posedge clk); #1;
                eng_done = 1'b1;
                eng_y    = (eng_mode == 0) ? 16'(int'(eng_band) * 100) : eng_const;
            end
        end
    end

    always @(negedge clk) begin
        if (eng_start) begin
            start_cnt++;
            band_log.push_back(int'(eng_band));
            if (eng_x != exp_x) xbad_cnt++;
        end
        if (y_valid) yv_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sample(input logic [15:0] x);
        tick(1);
        new_data = 1'b1;
        x_in     = x;
        exp_x    = x;
        tick(1);
        new_data = 1'b0;
    endtask

    task automatic write_gain(input logic [2:0] a, input logic [15:0] d);
        tick(1);
        gain_we = 1'b1; gain_addr = a; gain_wdata = d;
        tick(1);
        gain_we = 1'b0;
    endtask

    // Returns in the y_valid cycle; lat counts cycles from the new_data cycle.
    task automatic wait_result(output logic [15:0] y, output int lat);
        y   = 16'd0;
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            if (y_valid) begin
                y   = y_out;
                lat = i;
                return;
            end
            tick(1);
        end
        check("y_valid_wait", 0, 1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    logic [15:0] y;
    int          lat;
    int          yv_before;
    bit          found;
    bit          seq_ok;

    initial begin
        // Reset state
        tick(3);
        check("rst_flags", {eng_start, y_valid, busy, overrun, eng_timeout}, 0);
        check("rst_y_out", y_out, 0);
        check("rst_eng_x_band", {eng_x, 13'd0, eng_band}, 0);
        rst_n = 1'b1;
        tick(2);

        // Unity gains, eng_y = band*100
        eng_mode = 0;
        pulse_sample(16'h1234);
        wait_result(y, lat);
        check("t1_y_out", y, 1000);
        check("t1_latency", lat, 27);
        tick(1);
        check("t1_yv_single", {y_valid, busy}, 0);
        check("t1_yv_count", yv_cnt, 1);
        check("t1_start_count", start_cnt, 5);
        check("t1_eng_x_stable", xbad_cnt, 0);
        seq_ok = (band_log.size() == 5);
        foreach (band_log[i]) if (band_log[i] != i) seq_ok = 1'b0;
        check("t1_band_seq", seq_ok, 1);

        // Saturation with gain[2] = 2.0
        write_gain(3'd0, 16'h0000);
        write_gain(3'd1, 16'h0000);
        write_gain(3'd2, 16'h8000);
        write_gain(3'd3, 16'h0000);
        write_gain(3'd4, 16'h0000);
        write_gain(3'd5, 16'h7FFF);
        eng_mode = 1;
        eng_const = 16'h6000;
        pulse_sample(16'h0001);
        wait_result(y, lat);
        check("t2_sat_pos", y, 16'h7FFF);
        eng_const = 16'hA000;
        pulse_sample(16'h0002);
        wait_result(y, lat);
        check("t2_sat_neg", y, 16'h8000);
        eng_const = 16'hFF00;
        pulse_sample(16'h0003);
        wait_result(y, lat);
        check("t2_neg_nosat", y, 16'hFE00);

        // Gain write mid-sample only affects the next sample
        eng_const = 16'h0100;
        pulse_sample(16'h0004);
        tick(6);
        write_gain(3'd2, 16'h4000);
        wait_result(y, lat);
        check("t3_sample_a_old_gain", y, 16'd512);
        pulse_sample(16'h0005);
        wait_result(y, lat);
        check("t3_sample_b_new_gain", y, 16'd256);
        tick(1);
        new_data = 1'b1; x_in = 16'h0006; exp_x = 16'h0006;
        gain_we = 1'b1; gain_addr = 3'd2; gain_wdata = 16'h2000;
        tick(1);
        new_data = 1'b0; gain_we = 1'b0;
        wait_result(y, lat);
        check("t3_same_cycle_write", y, 16'd128);

        // Overrun while busy and in the y_valid cycle
        tick(1);
        check("t4_overrun_pre", overrun, 0);
        eng_mode = 0;
        start_cnt = 0;
        xbad_cnt = 0;
        band_log.delete();
        pulse_sample(16'h0777);
        tick(10);
        check("t4_busy_mid", busy, 1);
        new_data = 1'b1; x_in = 16'h1111;
        tick(1);
        new_data = 1'b0;
        check("t4_overrun_set", overrun, 1);
        wait_result(y, lat);
        check("t4_y_out", y, 16'd100);
        new_data = 1'b1; x_in = 16'h2222;
        tick(1);
        new_data = 1'b0;
        tick(10);
        check("t4_start_count", start_cnt, 5);
        check("t4_eng_x_stable", xbad_cnt, 0);
        check("t4_idle_after", busy, 0);

        // Engine timeout on band 3
        do_reset();
        check("t5_tmo_pre", {eng_timeout, overrun}, 0);
        start_cnt = 0;
        band_log.delete();
        withhold_band = 3;
        pulse_sample(16'h0100);
        wait_result(y, lat);
        check("t5_y_out", y, 16'd700);
        check("t5_latency", lat, 41);
        check("t5_timeout_flag", eng_timeout, 1);
        tick(1);
        check("t5_start_count", start_cnt, 5);
        check("t5_last_band", (band_log.size() == 5) ? band_log[4] : -1, 4);
        withhold_band = -1;

        // Reset during WAIT of band 2
        do_reset();
        pulse_sample(16'h0042);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (eng_start && (eng_band == 3'd2)) found = 1'b1;
            else tick(1);
        end
        check("t6_reach_band2", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_outs", {eng_start, busy, y_valid, eng_band}, 0);
        check("t6_async_eng_x", eng_x, 0);
        yv_before = yv_cnt;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t6_no_abort_yv", yv_cnt - yv_before, 0);
        start_cnt = 0;
        xbad_cnt = 0;
        band_log.delete();
        pulse_sample(16'h0099);
        wait_result(y, lat);
        check("t6_y_out", y, 16'd1000);
        tick(1);
        check("t6_yv_count", yv_cnt - yv_before, 1);
        seq_ok = (band_log.size() == 5);
        foreach (band_log[i]) if (band_log[i] != i) seq_ok = 1'b0;
        check("t6_band_seq", seq_ok, 1);
        check("t6_eng_x_stable", xbad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
